jogo_sequencia_unidade_controle: RTL and testbench

Moore control unit for the sequence-memory game datapath: it sequences the play-address counter (E), round counter (L), play register (R) and play-timeout timer (T) through rounds of growing length. In each round the player repeats memory entries 0..L. One wrong play or a timeout ends the game. The block sits beside the datapath in the game top level and only drives counter/register enables and status flags.

---
 rtl/jogo_sequencia_unidade_controle.sv | 118 +++++++++++
 tb/tb_jogo_sequencia_unidade_controle.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/jogo_sequencia_unidade_controle.sv
// Moore control unit for the sequence-memory game: drives datapath enables and end-of-game flags.
// Define TIMEOUT_EN to enable the play timer (contaT) and the timeout ending (fim_timeout).
module jogo_sequencia_unidade_controle (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       chavesIgualMemoria,
    input  logic       fimE,
    input  logic       fimL,
    input  logic       timeout,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraT,
    output logic       contaT,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        inicial        = 4'h0,
        preparacao     = 4'h1,
        inicia_rodada  = 4'h2,
        espera_jogada  = 4'h3,
        registra       = 4'h4,
        comparacao     = 4'h5,
        proxima_jogada = 4'h6,
        proxima_rodada = 4'h7,
        fim_acertou    = 4'hA,
        fim_timeout    = 4'hD,
        fim_errou      = 4'hE
    } estado_t;

    estado_t estado, proximo;
    logic    timeout_ok;

`ifdef TIMEOUT_EN
    assign timeout_ok = timeout;
`else
    // Timer disabled: the input is deliberately left unconnected to the FSM.
    logic unused_timeout;
    assign unused_timeout = timeout;
    assign timeout_ok     = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) estado <= inicial;
        else          estado <= proximo;
    end

    always_comb begin
        proximo = inicial;
        case (estado)
            inicial:        proximo = iniciar ? preparacao : inicial;
            preparacao:     proximo = inicia_rodada;
            inicia_rodada:  proximo = espera_jogada;
            // A play wins over a simultaneous timeout.
            espera_jogada:  proximo = jogada     ? registra    :
                                      timeout_ok ? fim_timeout : espera_jogada;
            registra:       proximo = comparacao;
            comparacao:     proximo = !chavesIgualMemoria ? fim_errou      :
                                      (fimE && fimL)      ? fim_acertou    :
                                      fimE                ? proxima_rodada : proxima_jogada;
            proxima_jogada: proximo = espera_jogada;
            proxima_rodada: proximo = inicia_rodada;
            fim_acertou,
            fim_errou,
            fim_timeout:    proximo = iniciar ? preparacao : estado;
            default:        proximo = inicial;
        endcase
    end

    always_comb begin
        zeraE      = 1'b0;
        contaE     = 1'b0;
        zeraL      = 1'b0;
        contaL     = 1'b0;
        zeraR      = 1'b0;
        registraR  = 1'b0;
        zeraT      = 1'b0;
        contaT     = 1'b0;
        pronto     = 1'b0;
        acertou    = 1'b0;
        errou      = 1'b0;
        db_timeout = 1'b0;
        db_estado  = estado;
        case (estado)
            inicial:        begin zeraE = 1'b1; zeraL = 1'b1; zeraR = 1'b1; end
            preparacao:     begin zeraE = 1'b1; zeraL = 1'b1; zeraR = 1'b1; zeraT = 1'b1; end
            inicia_rodada:  begin zeraE = 1'b1; zeraT = 1'b1; end
`ifdef TIMEOUT_EN
            espera_jogada:  contaT = 1'b1;
`else
            espera_jogada:  contaT = 1'b0;
`endif
            registra:       registraR = 1'b1;
            comparacao:     ;
            proxima_jogada: begin contaE = 1'b1; zeraT = 1'b1; end
            proxima_rodada: contaL = 1'b1;
            fim_acertou:    begin pronto = 1'b1; acertou = 1'b1; end
            fim_errou:      begin pronto = 1'b1; errou = 1'b1; end
`ifdef TIMEOUT_EN
            fim_timeout:    begin pronto = 1'b1; db_timeout = 1'b1; end
`else
            fim_timeout:    pronto = 1'b1;
`endif
            default:        db_estado = 4'hF;
        endcase
    end

endmodule

// File: tb/tb_jogo_sequencia_unidade_controle.sv
// Bench for the sequence-game control unit: table-driven state walk plus reset/timeout corners.
module tb_jogo_sequencia_unidade_controle;

    logic       clock = 1'b0;
    logic       reset_n, iniciar, jogada, chavesIgualMemoria, fimE, fimL, timeout;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT;
    logic       pronto, acertou, errou, db_timeout;
    logic [3:0] db_estado;

    int passed = 0;
    int total  = 0;
    int n_contaE, n_contaL;

    jogo_sequencia_unidade_controle dut (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .jogada(jogada),
        .chavesIgualMemoria(chavesIgualMemoria), .fimE(fimE), .fimL(fimL), .timeout(timeout),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL), .zeraR(zeraR),
        .registraR(registraR), .zeraT(zeraT), .contaT(contaT), .pronto(pronto),
        .acertou(acertou), .errou(errou), .db_timeout(db_timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       ini, jog, chv, fe, fl, to;
        logic [3:0] st;
    } vec_t;

    function automatic vec_t mk(logic ini, logic jog, logic chv, logic fe, logic fl,
                                logic to, logic [3:0] st);
        vec_t v;
        v.ini = ini; v.jog = jog; v.chv = chv; v.fe = fe; v.fl = fl; v.to = to; v.st = st;
        return v;
    endfunction

    // Expected {zeraE,contaE,zeraL,contaL,zeraR,registraR,zeraT,contaT,pronto,acertou,errou,db_timeout}
    function automatic logic [11:0] exp_out(logic [3:0] s);
        case (s)
            4'h0:    return 12'b1010_1000_0000;
            4'h1:    return 12'b1010_1010_0000;
            4'h2:    return 12'b1000_0010_0000;
`ifdef TIMEOUT_EN
            4'h3:    return 12'b0000_0001_0000;
            4'hD:    return 12'b0000_0000_1001;
`else
            4'h3:    return 12'b0000_0000_0000;
`endif
            4'h4:    return 12'b0000_0100_0000;
            4'h6:    return 12'b0100_0010_0000;
            4'h7:    return 12'b0001_0000_0000;
            4'hA:    return 12'b0000_0000_1100;
            4'hE:    return 12'b0000_0000_1010;
            default: return 12'b0000_0000_0000;
        endcase
    endfunction

    function automatic logic [11:0] outs();
        return {zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
                pronto, acertou, errou, db_timeout};
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk_state(input string name, input logic [3:0] st);
        chk({name, " estado"}, {8'h0, db_estado}, {8'h0, st});
        chk({name, " saidas"}, outs(), exp_out(st));
    endtask

    // Drive one vector at negedge, take one rising edge, check on the following negedge.
    task automatic step(input string name, input vec_t v);
        iniciar = v.ini; jogada = v.jog; chavesIgualMemoria = v.chv;
        fimE = v.fe; fimL = v.fl; timeout = v.to;
        @(posedge clock);
        @(negedge clock);
        n_contaE += int'(contaE);
        n_contaL += int'(contaL);
        chk_state(name, v.st);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        iniciar = 0; jogada = 0; chavesIgualMemoria = 0; fimE = 0; fimL = 0; timeout = 0;
        @(negedge clock);
        chk_state("reset", 4'h0);
        reset_n = 1'b1;
    endtask

    vec_t tbl[23];

    initial begin
        // Win in round 0, restart, then round 0 ok, round 1: first play ok, second wrong.
        tbl[0]  = mk(1,0,0,0,0,0, 4'h1);
        tbl[1]  = mk(0,0,0,0,0,0, 4'h2);
        tbl[2]  = mk(0,0,0,0,0,0, 4'h3);
        tbl[3]  = mk(0,1,1,1,1,0, 4'h4);
        tbl[4]  = mk(0,0,1,1,1,0, 4'h5);
        tbl[5]  = mk(0,0,1,1,1,0, 4'hA);
        tbl[6]  = mk(0,0,0,0,0,0, 4'hA);
        tbl[7]  = mk(1,0,0,0,0,0, 4'h1);
        tbl[8]  = mk(0,0,0,0,0,0, 4'h2);
        tbl[9]  = mk(0,0,0,0,0,0, 4'h3);
        tbl[10] = mk(0,1,1,1,0,0, 4'h4);
        tbl[11] = mk(0,0,1,1,0,0, 4'h5);
        tbl[12] = mk(0,0,1,1,0,0, 4'h7);
        tbl[13] = mk(0,0,0,0,0,0, 4'h2);
        tbl[14] = mk(0,0,0,0,0,0, 4'h3);
        tbl[15] = mk(0,1,1,0,0,0, 4'h4);
        tbl[16] = mk(0,0,1,0,0,0, 4'h5);
        tbl[17] = mk(0,0,1,0,0,0, 4'h6);
        tbl[18] = mk(0,0,0,0,0,0, 4'h3);
        tbl[19] = mk(0,1,0,1,0,0, 4'h4);
        tbl[20] = mk(0,0,0,1,0,0, 4'h5);
        tbl[21] = mk(0,0,0,1,0,0, 4'hE);
        tbl[22] = mk(0,0,0,0,0,0, 4'hE);

        reset_n = 1'b0;
        n_contaE = 0; n_contaL = 0;
        do_reset();
        step("idle", mk(0,0,0,0,0,0, 4'h0));

        for (int i = 0; i < 23; i++) begin
            if (i == 7) begin n_contaE = 0; n_contaL = 0; end
            step($sformatf("vec%0d", i), tbl[i]);
        end
        chk("contaE pulses", 12'(n_contaE), 12'd1);
        chk("contaL pulses", 12'(n_contaL), 12'd1);

        // Two rounds all correct, ending in a win.
        n_contaL = 0;
        step("2r ini", mk(1,0,0,0,0,0, 4'h1));
        step("2r p",   mk(0,0,0,0,0,0, 4'h2));
        step("2r r0",  mk(0,0,0,0,0,0, 4'h3));
        step("2r j0",  mk(0,1,1,1,0,0, 4'h4));
        step("2r c0a", mk(0,0,1,1,0,0, 4'h5));
        step("2r c0b", mk(0,0,1,1,0,0, 4'h7));
        step("2r r1",  mk(0,0,0,0,1,0, 4'h2));
        step("2r w1",  mk(0,0,0,0,1,0, 4'h3));
        step("2r j1",  mk(0,1,1,0,1,0, 4'h4));
        step("2r c1a", mk(0,0,1,0,1,0, 4'h5));
        step("2r c1b", mk(0,0,1,0,1,0, 4'h6));
        step("2r w2",  mk(0,0,0,0,1,0, 4'h3));
        step("2r j2",  mk(0,1,1,1,1,0, 4'h4));
        step("2r c2a", mk(0,0,1,1,1,0, 4'h5));
        step("2r c2b", mk(0,0,1,1,1,0, 4'hA));
        chk("2r contaL", 12'(n_contaL), 12'd1);

        // Asynchronous reset in the middle of espera_jogada, checked before the next edge.
        step("ar ini", mk(1,0,0,0,0,0, 4'h1));
        step("ar p",   mk(0,0,0,0,0,0, 4'h2));
        step("ar w",   mk(0,0,0,0,0,0, 4'h3));
        #2 reset_n = 1'b0;
        #1 chk_state("async reset", 4'h0);
        @(negedge clock);
        reset_n = 1'b1;
        step("post reset", mk(0,0,0,0,0,0, 4'h0));

        // Timeout while waiting for a play.
        step("to ini", mk(1,0,0,0,0,0, 4'h1));
        step("to p",   mk(0,0,0,0,0,0, 4'h2));
        step("to w",   mk(0,0,0,0,0,0, 4'h3));
`ifdef TIMEOUT_EN
        step("to hit", mk(0,0,0,0,0,1, 4'hD));
        step("to hold", mk(0,0,0,0,0,0, 4'hD));
        step("to rst", mk(1,0,0,0,0,0, 4'h1));
        step("to p2",  mk(0,0,0,0,0,0, 4'h2));
        step("to w2",  mk(0,0,0,0,0,0, 4'h3));
`else
        step("to ign", mk(0,0,0,0,0,1, 4'h3));
        step("to ign2", mk(1,0,0,0,0,1, 4'h3));
`endif
        // Play and timeout together: the play wins.
        step("to+jog", mk(0,1,1,0,0,1, 4'h4));
        step("to+jog c", mk(0,0,1,0,0,0, 4'h5));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
